wb_stage: RTL and testbench

- Writeback stage of the RISC-V pipeline; the writer end of the register-file write port (we/waddr/wdata).
- Accepts completed results from the MEM stage over a valid/ready handshake.
- ALU results are written back after a 1-cycle register stage.
- Loads wait for the data-memory response, then byte/half extraction and sign/zero extension, then write. Misaligned accesses, illegal load types and response timeouts are flagged.

---
 rtl/wb_stage.sv | 174 +++++++++++++++++
 tb/tb_wb_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: takes completed MEM-stage results and drives the register
// file write port. ALU results are written one cycle after acceptance; loads
// wait for the data-memory response, extract and extend the addressed
// byte/half/word, then write. Misaligned, illegal-type and timed-out loads
// raise a one-cycle err pulse instead of writing.
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wreg,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_wdata,
    input  logic        in_is_load,
    input  logic [2:0]  in_load_type,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_wreg_q, ld_wreg_d;
    logic [2:0]      ld_type_q, ld_type_d;
    logic [1:0]      ld_addr_q, ld_addr_d;

    // A load is rejected when its type is not a defined funct3 or its address
    // is not naturally aligned for the access size.
    function automatic logic load_bad(input logic [2:0] ty, input logic [1:0] a);
        logic bad;
        case (ty)
            LT_LB, LT_LBU: bad = 1'b0;
            LT_LH, LT_LHU: bad = a[0];
            LT_LW:         bad = (a != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian byte/half selection followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0]  ty,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (ty)
            LT_LB:   r = {{24{b[7]}}, b};
            LT_LH:   r = {{16{h[15]}}, h};
            LT_LW:   r = d;
            LT_LBU:  r = {24'h000000, b};
            LT_LHU:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == ST_IDLE);
    assign we       = we_q;
    assign err      = err_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

    // Next-state, counter and registered-output computation for both states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ld_rd_d   = ld_rd_q;
        ld_wreg_d = ld_wreg_q;
        ld_type_d = ld_type_q;
        ld_addr_d = ld_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!in_is_load) begin
                        we_d    = in_wreg & (in_waddr != 5'd0);
                        waddr_d = in_waddr;
                        wdata_d = in_wdata;
                    end else if (load_bad(in_load_type, in_wdata[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        ld_rd_d   = in_waddr;
                        ld_wreg_d = in_wreg;
                        ld_type_d = in_load_type;
                        ld_addr_d = in_wdata[1:0];
                        cnt_d     = CNT_ZERO;
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still counts as data.
                if (mem_rvalid) begin
                    we_d    = ld_wreg_q & (ld_rd_q != 5'd0);
                    waddr_d = ld_rd_q;
                    wdata_d = load_extract(ld_type_q, ld_addr_q, mem_rdata);
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            waddr_q   <= 5'd0;
            wdata_q   <= 32'h0000_0000;
            ld_rd_q   <= 5'd0;
            ld_wreg_q <= 1'b0;
            ld_type_q <= 3'b000;
            ld_addr_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            err_q     <= err_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ld_rd_q   <= ld_rd_d;
            ld_wreg_q <= ld_wreg_d;
            ld_type_q <= ld_type_d;
            ld_addr_q <= ld_addr_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a transaction-level scoreboard keyed by clock edge,
// filled by the driver from the stage's rules, and one compare process that
// checks every cycle's outputs against it.
module tb_wb_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wreg;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic [2:0]  in_load_type;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;

    int edge_n   = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    bit rst_chk  = 1'b0;

    // Expected events indexed by the edge after which they are visible:
    // kind 1 = write, kind 2 = err. exp_busy marks edges where in_ready is 0.
    int          exp_kind[int];
    logic [4:0]  exp_addr[int];
    logic [31:0] exp_data[int];
    bit          exp_busy[int];

    wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wreg      (in_wreg),
        .in_waddr     (in_waddr),
        .in_wdata     (in_wdata),
        .in_is_load   (in_is_load),
        .in_load_type (in_load_type),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference rules: access size from funct3, legal iff address is a multiple of it.
    function automatic bit m_legal(input logic [2:0] ty, input logic [31:0] addr);
        int size;
        case (ty)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) return 1'b0;
        return (int'(addr[1:0]) % size) == 0;
    endfunction

    function automatic logic [31:0] m_extract(input logic [2:0] ty, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(addr[1:0]);
        v  = rdata >> sh;
        case (ty)
            3'd0: begin v = v & 32'h0000_00FF; if (v >= 32'h80)   v = v - 32'h100;   end
            3'd4: v = v & 32'h0000_00FF;
            3'd1: begin v = v & 32'h0000_FFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'd5: v = v & 32'h0000_FFFF;
            3'd2: v = rdata;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exv);
        n_checks++;
        if (act !== exv) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, edge_n, act, exv);
        end
    endtask

    // Single compare process: outputs are sampled on the falling edge.
    initial begin
        int   n;
        int   k;
        logic e_we;
        logic e_err;
        bit   pinned;
        pinned = 1'b0;
        forever begin
            @(negedge clk);
            n = edge_n;
            if (rst_chk) begin
                check("rst_we",       32'(we),       32'd0);
                check("rst_err",      32'(err),      32'd0);
                check("rst_waddr",    32'(waddr),    32'd0);
                check("rst_wdata",    wdata,         32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd1);
            end else if (chk_on) begin
                if (!pinned) begin
                    pinned = 1'b1;
                    check("pin_lb",   m_extract(3'd0, 32'h1003, 32'h80FF1234), 32'hFFFFFF80);
                    check("pin_lhu",  m_extract(3'd5, 32'h1002, 32'h80FF1234), 32'h000080FF);
                    check("pin_lw",   m_extract(3'd2, 32'h1000, 32'h80FF1234), 32'h80FF1234);
                    check("pin_mis",  32'(m_legal(3'd2, 32'h1002)), 32'd0);
                end
                k = 0;
                if (exp_kind.exists(n)) k = exp_kind[n];
                e_we  = (k == 1);
                e_err = (k == 2);
                check("we",       32'(we),       32'(e_we));
                check("err",      32'(err),      32'(e_err));
                check("in_ready", 32'(in_ready), 32'(!exp_busy.exists(n)));
                if (e_we) begin
                    check("waddr", 32'(waddr), 32'(exp_addr[n]));
                    check("wdata", wdata,      exp_data[n]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_write(input int e, input bit wreg, input logic [4:0] rd, input logic [31:0] d);
        if (wreg && rd != 5'd0) begin
            exp_kind[e] = 1;
            exp_addr[e] = rd;
            exp_data[e] = d;
        end
    endtask

    task automatic junk_fields();
        in_wreg      = 1'($urandom);
        in_waddr     = 5'($urandom);
        in_wdata     = $urandom;
        in_is_load   = 1'($urandom);
        in_load_type = 3'($urandom);
    endtask

    task automatic idle_tick();
        junk_fields();
        in_valid   = 1'b0;
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        tick();
    endtask

    // Random non-accepted traffic while the stage is busy waiting.
    task automatic junk_wait();
        junk_fields();
        in_valid   = 1'($urandom);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
    endtask

    task automatic send_alu(input bit wreg, input logic [4:0] rd, input logic [31:0] d);
        int a;
        a            = edge_n + 1;
        in_valid     = 1'b1;
        in_is_load   = 1'b0;
        in_load_type = 3'($urandom);
        in_wreg      = wreg;
        in_waddr     = rd;
        in_wdata     = d;
        mem_rvalid   = 1'($urandom);
        mem_rdata    = $urandom;
        exp_write(a, wreg, rd, d);
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // d in 1..TIMEOUT: rvalid sampled d edges after acceptance; otherwise timeout,
    // followed by a late rvalid that must be ignored.
    task automatic send_load(input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] rdata,
                             input int d, input logic [4:0] rd, input bit wreg,
                             input logic [31:0] expd);
        int a;
        a            = edge_n + 1;
        in_valid     = 1'b1;
        in_is_load   = 1'b1;
        in_load_type = ty;
        in_wreg      = wreg;
        in_waddr     = rd;
        in_wdata     = addr;
        mem_rvalid   = 1'($urandom);
        mem_rdata    = $urandom;
        if (!m_legal(ty, addr)) begin
            exp_kind[a] = 2;
            tick();
        end else if (d >= 1 && d <= TIMEOUT) begin
            for (int e = a; e < a + d; e++) exp_busy[e] = 1'b1;
            exp_write(a + d, wreg, rd, expd);
            tick();
            repeat (d - 1) begin junk_wait(); tick(); end
            junk_wait();
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
        end else begin
            for (int e = a; e < a + TIMEOUT; e++) exp_busy[e] = 1'b1;
            exp_kind[a + TIMEOUT] = 2;
            tick();
            repeat (TIMEOUT) begin junk_wait(); tick(); end
            in_valid   = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Driver: reset, directed scenarios, then randomized traffic.
    initial begin
        int a;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_wreg      = 1'b0;
        in_waddr     = 5'd0;
        in_wdata     = 32'd0;
        in_is_load   = 1'b0;
        in_load_type = 3'd0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'd0;
        repeat (3) tick();
        rst     = 1'b1;
        rst_chk = 1'b1;
        chk_on  = 1'b1;
        tick();
        rst_chk = 1'b0;

        // ALU writes, including three back-to-back accepts.
        send_alu(1'b1, 5'd5, 32'hDEADBEEF);
        idle_tick();
        send_alu(1'b1, 5'd1, 32'h11111111);
        send_alu(1'b1, 5'd2, 32'h22222222);
        send_alu(1'b1, 5'd3, 32'h33333333);
        idle_tick();
        // x0 is never written.
        send_alu(1'b1, 5'd0, 32'hCAFEF00D);
        idle_tick();

        // Load extraction with literal expectations.
        send_load(3'b000, 32'h1003, 32'h80FF1234, 3, 5'd10, 1'b1, 32'hFFFFFF80);
        send_load(3'b100, 32'h1003, 32'h80FF1234, 3, 5'd11, 1'b1, 32'h00000080);
        send_load(3'b001, 32'h1002, 32'h80FF1234, 2, 5'd12, 1'b1, 32'hFFFF80FF);
        send_load(3'b101, 32'h1002, 32'h80FF1234, 1, 5'd13, 1'b1, 32'h000080FF);
        send_load(3'b010, 32'h1000, 32'h80FF1234, 4, 5'd14, 1'b1, 32'h80FF1234);
        idle_tick();

        // Error cases.
        send_load(3'b001, 32'h1001, 32'h0, 2, 5'd15, 1'b1, 32'h0);
        send_load(3'b010, 32'h1002, 32'h0, 2, 5'd16, 1'b1, 32'h0);
        send_load(3'b111, 32'h1000, 32'h0, 2, 5'd17, 1'b1, 32'h0);
        idle_tick();

        // Timeout with late rvalid, then rvalid on the last wait cycle.
        send_load(3'b010, 32'h1000, 32'h12345678, 0, 5'd18, 1'b1, 32'h0);
        send_load(3'b010, 32'h1000, 32'h87654321, TIMEOUT, 5'd19, 1'b1, 32'h87654321);
        idle_tick();

        // Reset in the middle of a wait abandons the load.
        a            = edge_n + 1;
        exp_busy[a]     = 1'b1;
        exp_busy[a + 1] = 1'b1;
        in_valid     = 1'b1;
        in_is_load   = 1'b1;
        in_load_type = 3'b010;
        in_wreg      = 1'b1;
        in_waddr     = 5'd7;
        in_wdata     = 32'h2000;
        mem_rvalid   = 1'b0;
        tick();
        junk_wait();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        rst        = 1'b1;
        rst_chk    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5A5A5;
        tick();
        rst_chk    = 1'b0;
        mem_rvalid = 1'b0;
        idle_tick();
        send_alu(1'b1, 5'd9, 32'h0BADC0DE);
        idle_tick();

        // Randomized traffic checked against the reference rules.
        for (int i = 0; i < 250; i++) begin
            logic [2:0]  ty;
            logic [31:0] ad;
            logic [31:0] rd_word;
            logic [4:0]  rd;
            bit          wr;
            rd = 5'($urandom);
            wr = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 4) begin
                send_alu(wr, rd, $urandom);
            end else begin
                ty      = 3'($urandom);
                ad      = $urandom;
                rd_word = $urandom;
                send_load(ty, ad, rd_word, $urandom_range(1, TIMEOUT + 2), rd, wr,
                          m_extract(ty, ad, rd_word));
            end
            repeat ($urandom_range(0, 2)) idle_tick();
        end

        repeat (3) idle_tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
